// File: rtl/stepdown_fault_pkg.sv
// Shared FSM state type, parameter defaults and helpers for the stepdown fault receiver.
package stepdown_fault_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_LATCHED = 2'd2,
    ST_RECOVER = 2'd3
  } fault_state_e;

  localparam int unsigned DEB_CYC_DEF = 8;
  localparam int unsigned REC_CYC_DEF = 16;
  localparam int unsigned FLT_CNT_W   = 8;

  localparam logic [FLT_CNT_W-1:0] FLT_CNT_MAX = '1;

  // Event counter increment that sticks at full scale.
  function automatic logic [FLT_CNT_W-1:0] flt_cnt_sat_inc(input logic [FLT_CNT_W-1:0] v);
    return (v == FLT_CNT_MAX) ? v : v + FLT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/celsync2.sv
// Two-flop synchronizer for one asynchronous level; both flops reset to 0.
module celsync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/stepdown_fault_rx.sv
// Debounced fault latch with controller clear and timed recovery for the stepdown converter.
// Define STEPDOWN_FAULT_RX_AUTORETRY_EN to leave LATCHED as soon as the fault line is clean.
module stepdown_fault_rx
  import stepdown_fault_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned REC_CYC = REC_CYC_DEF,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       CELCLK,
  input  logic       CELRSTN,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       fault_n,
  input  logic       clr_req,
  output logic       shdn,
  output logic       flt_flag,
  output logic       clr_ack,
  output logic [7:0] flt_cnt,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);

  fault_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 shdn_q, shdn_d;
  logic                 flag_q, flag_d;
  logic                 ack_q, ack_d;
  logic [FLT_CNT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic                 fault_s;
  logic                 unused_supplies;

  assign unused_supplies = ^{CELV, CELG, SUB};

  // Synchronize the inverted line so the flops' reset value reads as "no fault".
  celsync2 u_sync (
    .clk   (CELCLK),
    .rst_n (CELRSTN),
    .d_i   (~fault_n),
    .q_o   (fault_s)
  );

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shdn_q    <= 1'b0;
      flag_q    <= 1'b0;
      ack_q     <= 1'b0;
      flt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shdn_q    <= shdn_d;
      flag_q    <= flag_d;
      ack_q     <= ack_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  // Next-state logic; the one counter serves debounce in QUAL and clean-time in RECOVER.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shdn_d    = shdn_q;
    flag_d    = flag_q;
    ack_d     = 1'b0;
    flt_cnt_d = flt_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fault_s) begin
          state_d = ST_QUAL;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_QUAL: begin
        if (!fault_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_LATCHED;
          cnt_d     = '0;
          shdn_d    = 1'b1;
          flag_d    = 1'b1;
          flt_cnt_d = flt_cnt_sat_inc(flt_cnt_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCHED: begin
        cnt_d = '0;
`ifdef STEPDOWN_FAULT_RX_AUTORETRY_EN
        if (!fault_s) begin
          state_d = ST_RECOVER;
          ack_d   = clr_req;
        end
`else
        if (!fault_s && clr_req) begin
          state_d = ST_RECOVER;
          ack_d   = 1'b1;
        end
`endif
      end
      ST_RECOVER: begin
        if (fault_s) begin
          state_d = ST_LATCHED;
          cnt_d   = '0;
        end else if (cnt_q == REC_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          shdn_d  = 1'b0;
          flag_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign shdn     = shdn_q;
  assign flt_flag = flag_q;
  assign clr_ack  = ack_q;
  assign flt_cnt  = flt_cnt_q;
  assign state    = state_q;

endmodule
